// File: rtl/sha256_digest_uart_tx_pkg.sv
// Shared definitions for the SHA-256 digest return path: FSM encoding,
// terminator characters and the nibble-to-ASCII helper.
package sha_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FRAME  = 2'd1,
    ST_TERM   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam int         DIGEST_BYTES = 32;

  // Lowercase hex: 0-9 -> '0'-'9', a-f -> 'a'-'f'.
  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
    logic [7:0] r;
    if (nib < 4'd10) r = 8'h30 + {4'h0, nib};
    else             r = 8'h57 + {4'h0, nib};
    return r;
  endfunction

endpackage

// File: rtl/sha256_digest_uart_tx_if.sv
// Digest handoff from sha256_core plus the UART-side status lines.
interface sha256_digest_uart_tx_if;
  logic [255:0] digest;
  logic         digest_valid;
  logic         uart_txd;
  logic         busy;
  logic         done;
  logic         overrun;

  modport master (output digest, digest_valid, input uart_txd, busy, done, overrun);
  modport slave  (input digest, digest_valid, output uart_txd, busy, done, overrun);
endinterface

// File: rtl/sha256_digest_uart_tx_byte.sv
// Single UART frame serialiser: start bit, 8 data bits LSB first, STOP_BITS
// stop bits. byte_done is high during the last cycle of the final stop bit
// and a byte_start seen in that cycle is loaded, so frames chain with no gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] byte_data,
  input  logic       byte_start,
  output logic       byte_busy,
  output logic       byte_done,
  output logic       txd
);

  localparam int FW = 9 + STOP_BITS;
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] r_clk_cnt;
  logic [3:0]    r_bit_cnt;
  logic [FW-1:0] r_shift;
  logic          r_busy;
  logic          r_txd;

  logic w_bit_end;
  logic w_done;
  logic w_load;

  assign w_bit_end = r_busy && (r_clk_cnt == '0);
  assign w_done    = w_bit_end && (r_bit_cnt == 4'(FW - 1));
  assign w_load    = byte_start && (!r_busy || w_done);

  assign byte_busy = r_busy;
  assign byte_done = w_done;
  assign txd       = r_txd;

  // Bit timer counts down per bit; the frame shifts out of r_shift one bit per terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy    <= 1'b0;
      r_txd     <= 1'b1;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_clk_cnt <= '0;
    end else if (w_load) begin
      r_busy    <= 1'b1;
      r_txd     <= 1'b0;
      r_shift   <= {{STOP_BITS{1'b1}}, byte_data, 1'b0};
      r_bit_cnt <= '0;
      r_clk_cnt <= CW'(CLKS_PER_BIT - 1);
    end else if (w_done) begin
      r_busy    <= 1'b0;
      r_txd     <= 1'b1;
    end else if (w_bit_end) begin
      r_shift   <= {1'b1, r_shift[FW-1:1]};
      r_txd     <= r_shift[1];
      r_bit_cnt <= r_bit_cnt + 4'd1;
      r_clk_cnt <= CW'(CLKS_PER_BIT - 1);
    end else if (r_busy) begin
      r_clk_cnt <= r_clk_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/sha256_digest_uart_tx.sv
// Captures a SHA-256 digest on a digest_valid rising edge and sends it out
// over UART as raw bytes or lowercase hex, optionally followed by CR LF.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | waiting for a digest_valid rising edge
//   ST_FRAME  | sending digest symbols (bytes or hex characters)
//   ST_TERM   | sending the CR LF terminator
//   ST_FINISH | one-cycle done pulse, line idle, then back to IDLE
module sha256_digest_uart_tx
  import sha_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int HEX_ASCII    = 1,
  parameter int APPEND_CRLF  = 1
) (
  input logic                     clk,
  input logic                     reset_n,
  sha256_digest_uart_tx_if.slave  bus
);

  localparam int N_DIG = (HEX_ASCII != 0) ? 2 * DIGEST_BYTES : DIGEST_BYTES;
  localparam int N_SYM = N_DIG + ((APPEND_CRLF != 0) ? 2 : 0);

  state_t       r_state;
  logic         r_dv_q;
  logic         r_busy;
  logic         r_done;
  logic         r_overrun;
  logic [255:0] r_dig;
  logic [6:0]   r_sym;

  logic       w_rise;
  logic       w_capture;
  logic [6:0] w_sym_next;
  logic       w_byte_start;
  logic [7:0] w_byte_data;
  logic       w_byte_busy;
  logic       w_byte_done;
  logic       w_txd;

  // Symbol idx of a message: digest bytes/characters first, then CR, then LF.
  function automatic logic [7:0] f_symbol(input logic [255:0] dig, input logic [6:0] idx);
    logic [255:0] t;
    logic [7:0]   b;
    logic [7:0]   r;
    if (idx == 7'(N_DIG)) begin
      r = ASCII_CR;
    end else if (idx == 7'(N_DIG + 1)) begin
      r = ASCII_LF;
    end else if (HEX_ASCII != 0) begin
      t = dig << {idx[6:1], 3'b000};
      b = t[255:248];
      r = nib_to_ascii(idx[0] ? b[3:0] : b[7:4]);
    end else begin
      t = dig << {idx, 3'b000};
      r = t[255:248];
    end
    return r;
  endfunction

  // The serialiser is always idle in ST_IDLE; the gate just keeps a capture from ever overlapping a frame.
  assign w_rise       = bus.digest_valid & ~r_dv_q;
  assign w_capture    = w_rise && (r_state == ST_IDLE) && !w_byte_busy;
  assign w_sym_next   = r_sym + 7'd1;
  assign w_byte_start = w_capture ||
                        (w_byte_done && (r_state == ST_FRAME || r_state == ST_TERM) &&
                         (w_sym_next < 7'(N_SYM)));
  assign w_byte_data  = w_capture ? f_symbol(bus.digest, 7'd0) : f_symbol(r_dig, w_sym_next);

  assign bus.uart_txd = w_txd;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.overrun  = r_overrun;

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .STOP_BITS    (STOP_BITS)
  ) u_byte (
    .clk        (clk),
    .reset_n    (reset_n),
    .byte_data  (w_byte_data),
    .byte_start (w_byte_start),
    .byte_busy  (w_byte_busy),
    .byte_done  (w_byte_done),
    .txd        (w_txd)
  );

  // Edge detector; resets high so a level already asserted when reset releases is not a new digest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_dv_q <= 1'b1;
    else          r_dv_q <= bus.digest_valid;
  end

  // Message sequencing, symbol counter and the registered busy/done/overrun flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_dig     <= '0;
      r_sym     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_rise && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            r_dig     <= bus.digest;
            r_sym     <= '0;
            r_busy    <= 1'b1;
            r_overrun <= 1'b0;
            r_state   <= ST_FRAME;
          end
        end
        ST_FRAME: begin
          if (w_byte_done) begin
            r_sym <= w_sym_next;
            if (r_sym == 7'(N_DIG - 1)) begin
              if (APPEND_CRLF != 0) begin
                r_state <= ST_TERM;
              end else begin
                r_state <= ST_FINISH;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end
        ST_TERM: begin
          if (w_byte_done) begin
            r_sym <= w_sym_next;
            if (r_sym == 7'(N_SYM - 1)) begin
              r_state <= ST_FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          r_sym   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_digest_uart_tx.sv
// Bench for sha256_digest_uart_tx: three configurations side by side, each
// message compared cycle by cycle against a line waveform built from the
// digest by a reference model.
module tb_sha256_digest_uart_tx;

  localparam logic [255:0] ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sha256_digest_uart_tx_if if_raw ();
  sha256_digest_uart_tx_if if_def ();
  sha256_digest_uart_tx_if if_s2 ();

  logic [255:0] dig_drv [3];
  logic         dv_drv  [3];

  assign if_raw.digest       = dig_drv[0];
  assign if_raw.digest_valid = dv_drv[0];
  assign if_def.digest       = dig_drv[1];
  assign if_def.digest_valid = dv_drv[1];
  assign if_s2.digest        = dig_drv[2];
  assign if_s2.digest_valid  = dv_drv[2];

  sha256_digest_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .HEX_ASCII(0), .APPEND_CRLF(0))
    u_raw (.clk(clk), .reset_n(reset_n), .bus(if_raw));
  sha256_digest_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .HEX_ASCII(1), .APPEND_CRLF(1))
    u_def (.clk(clk), .reset_n(reset_n), .bus(if_def));
  sha256_digest_uart_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2), .HEX_ASCII(0), .APPEND_CRLF(0))
    u_s2  (.clk(clk), .reset_n(reset_n), .bus(if_s2));

  int   sel;
  logic txd_m, busy_m, done_m, ovr_m;

  always_comb begin
    txd_m  = if_raw.uart_txd;
    busy_m = if_raw.busy;
    done_m = if_raw.done;
    ovr_m  = if_raw.overrun;
    case (sel)
      1: begin
        txd_m = if_def.uart_txd; busy_m = if_def.busy; done_m = if_def.done; ovr_m = if_def.overrun;
      end
      2: begin
        txd_m = if_s2.uart_txd; busy_m = if_s2.busy; done_m = if_s2.done; ovr_m = if_s2.overrun;
      end
      default: ;
    endcase
  end

  int           n_checks = 0;
  int           n_err = 0;
  bit           exp_wave [$];
  logic [7:0]   exp_syms [$];
  logic         cap [$];
  int           bad;
  logic [9:0]   pat;
  logic [255:0] rd;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_digest();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Reference: digest -> symbol list -> per-cycle line level.
  function automatic void build_model(input logic [255:0] d, input bit hex, input bit crlf,
                                      input int c, input int s);
    string      hexs = "0123456789abcdef";
    logic [7:0] b;
    exp_syms.delete();
    exp_wave.delete();
    for (int i = 0; i < 32; i++) begin
      b = d[255 - 8*i -: 8];
      if (hex) begin
        exp_syms.push_back(hexs[int'(b[7:4])]);
        exp_syms.push_back(hexs[int'(b[3:0])]);
      end else begin
        exp_syms.push_back(b);
      end
    end
    if (crlf) begin
      exp_syms.push_back(8'h0D);
      exp_syms.push_back(8'h0A);
    end
    foreach (exp_syms[k]) begin
      repeat (c) exp_wave.push_back(1'b0);
      for (int j = 0; j < 8; j++) repeat (c) exp_wave.push_back(exp_syms[k][j]);
      repeat (s * c) exp_wave.push_back(1'b1);
    end
  endfunction

  function automatic logic [7:0] dec_byte(input int f, input int c, input int s);
    logic [7:0] r;
    int base = f * (9 + s) * c;
    for (int j = 0; j < 8; j++) r[j] = cap[base + (1 + j) * c + c / 2];
    return r;
  endfunction

  function automatic int count_frames(input int c, input int s);
    int n = 0;
    for (int f = 0; (f + 1) * (9 + s) * c <= cap.size(); f++)
      if (cap[f * (9 + s) * c + c / 2] === 1'b0) n++;
    return n;
  endfunction

  // Raise digest_valid now (caller leaves it low for at least one edge before), follow the whole
  // message against the model, end sampling in the done cycle. Optional drop/re-raise mid-message.
  task automatic run_msg(input int s_idx, input logic [255:0] d, input int c, input int s,
                         input bit hex, input bit crlf, input int gl_at, input bit reraise,
                         input logic [255:0] gdig, input string tag);
    int mism = 0;
    int bbad = 0;
    build_model(d, hex, crlf, c, s);
    sel = s_idx;
    cap.delete();
    dig_drv[s_idx] = d;
    dv_drv[s_idx]  = 1'b1;
    for (int i = 0; i < exp_wave.size(); i++) begin
      @(negedge clk);
      cap.push_back(txd_m);
      if (txd_m !== exp_wave[i]) mism++;
      if (busy_m !== 1'b1 || done_m !== 1'b0) bbad++;
      if (gl_at >= 0 && i == gl_at) dv_drv[s_idx] = 1'b0;
      if (gl_at >= 0 && reraise && i == gl_at + 1) begin
        dig_drv[s_idx] = gdig;
        dv_drv[s_idx]  = 1'b1;
      end
    end
    check({tag, " wave mismatches"}, mism, 0);
    check({tag, " busy/done during msg"}, bbad, 0);
    @(negedge clk);
    check({tag, " done pulse"}, done_m, 1'b1);
    check({tag, " busy low at done"}, busy_m, 1'b0);
    check({tag, " line idle at done"}, txd_m, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      dig_drv[i] = '0;
      dv_drv[i]  = 1'b0;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset txd def", if_def.uart_txd, 1'b1);
    check("reset busy def", if_def.busy, 1'b0);
    check("reset done def", if_def.done, 1'b0);
    check("reset overrun def", if_def.overrun, 1'b0);
    check("reset txd raw", if_raw.uart_txd, 1'b1);
    check("reset txd s2", if_s2.uart_txd, 1'b1);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Raw bytes, no terminator.
    run_msg(0, ABC, 4, 1, 1'b0, 1'b0, -1, 1'b0, '0, "t1");
    check("t1 frames", count_frames(4, 1), 32);
    check("t1 first byte", dec_byte(0, 4, 1), 8'hBA);
    check("t1 last byte", dec_byte(31, 4, 1), 8'hAD);
    for (int k = 0; k < 10; k++) pat[k] = cap[4*k + 2];
    check("t1 first frame bits", pat, 10'b1101110100);
    dv_drv[0] = 1'b0;
    @(negedge clk);
    run_msg(0, rand_digest(), 4, 1, 1'b0, 1'b0, -1, 1'b0, '0, "t1 rand");
    dv_drv[0] = 1'b0;

    // Two stop bits, 3 clocks per bit.
    @(negedge clk);
    run_msg(2, ABC, 3, 2, 1'b0, 1'b0, -1, 1'b0, '0, "t6");
    check("t6 frames", count_frames(3, 2), 32);
    bad = 0;
    for (int k = 1; k < 32; k++) begin
      for (int t = 1; t <= 6; t++) if (cap[33*k - t] !== 1'b1) bad++;
      if (cap[33*k] !== 1'b0) bad++;
    end
    check("t6 stop gap", bad, 0);
    dv_drv[2] = 1'b0;
    @(negedge clk);
    run_msg(2, rand_digest(), 3, 2, 1'b0, 1'b0, -1, 1'b0, '0, "t6 rand");
    dv_drv[2] = 1'b0;

    // Defaults: hex + CR LF.
    @(negedge clk);
    run_msg(1, ABC, 4, 1, 1'b1, 1'b1, -1, 1'b0, '0, "t2");
    check("t2 frames", count_frames(4, 1), 66);
    check("t2 char0", dec_byte(0, 4, 1), 8'h62);
    check("t2 char1", dec_byte(1, 4, 1), 8'h61);
    check("t2 char63", dec_byte(63, 4, 1), 8'h64);
    check("t2 CR", dec_byte(64, 4, 1), 8'h0D);
    check("t2 LF", dec_byte(65, 4, 1), 8'h0A);

    // Rise in the first IDLE cycle after done is captured.
    dv_drv[1] = 1'b0;
    @(negedge clk);
    check("idle done low", done_m, 1'b0);
    check("idle busy low", busy_m, 1'b0);
    run_msg(1, rand_digest(), 4, 1, 1'b1, 1'b1, -1, 1'b0, '0, "b2b rand");

    // Held level: exactly one message in 5000 cycles.
    dv_drv[1] = 1'b0;
    @(negedge clk);
    run_msg(1, rand_digest(), 4, 1, 1'b1, 1'b1, -1, 1'b0, '0, "t3");
    bad = 0;
    for (int i = 0; i < 5000 - 2641; i++) begin
      @(negedge clk);
      if (txd_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0 || ovr_m !== 1'b0) bad++;
    end
    check("t3 no retrigger", bad, 0);

    // Second rise mid-message -> overrun, message unchanged; next rise sends the new digest.
    dv_drv[1] = 1'b0;
    @(negedge clk);
    run_msg(1, ABC, 4, 1, 1'b1, 1'b1, 405, 1'b1, 256'h1, "t4a");
    check("t4 overrun set", ovr_m, 1'b1);
    dv_drv[1] = 1'b0;
    @(negedge clk);
    check("t4 overrun sticky", ovr_m, 1'b1);
    run_msg(1, 256'h1, 4, 1, 1'b1, 1'b1, -1, 1'b0, '0, "t4b");
    check("t4 overrun cleared", ovr_m, 1'b0);

    // Rise in the done cycle: overrun, no capture.
    dv_drv[1] = 1'b0;
    @(negedge clk);
    run_msg(1, rand_digest(), 4, 1, 1'b1, 1'b1, 100, 1'b0, '0, "fin");
    check("fin overrun before", ovr_m, 1'b0);
    dv_drv[1] = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (txd_m !== 1'b1 || busy_m !== 1'b0) bad++;
    end
    check("fin not captured", bad, 0);
    check("fin overrun set", ovr_m, 1'b1);

    // Reset mid-bit of frame 5.
    dv_drv[1] = 1'b0;
    @(negedge clk);
    rd = rand_digest();
    build_model(rd, 1'b1, 1'b1, 4, 1);
    sel = 1;
    dig_drv[1] = rd;
    dv_drv[1]  = 1'b1;
    for (int i = 0; i <= 202; i++) begin
      @(negedge clk);
      if (i == 202) check("t5 start bit frame5", txd_m, exp_wave[202]);
    end
    #1 reset_n = 1'b0;
    #1;
    check("t5 txd high at reset", txd_m, 1'b1);
    check("t5 busy low at reset", busy_m, 1'b0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_m !== 1'b0 || txd_m !== 1'b1) bad++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (txd_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) bad++;
    end
    check("t5 quiet after reset", bad, 0);
    dv_drv[1] = 1'b0;
    @(negedge clk);
    run_msg(1, rand_digest(), 4, 1, 1'b1, 1'b1, -1, 1'b0, '0, "t5 recover");
    dv_drv[1] = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
